// File: rtl/riscv_ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Falls back to RV32 widths when the shared RISC-V defines header has not been read first.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

package riscv_ifq_pkg;

    localparam int XLEN = `XLEN;

    localparam logic ST_FETCH_ENC = 1'b0;
    localparam logic ST_DRAIN_ENC = 1'b1;

    typedef enum logic {
        FETCH = ST_FETCH_ENC,
        DRAIN = ST_DRAIN_ENC
    } ifq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/riscv_ifq_if.sv
// Fetch-queue bus: instruction-memory request/response plus the CPU-facing queue head.
// The master modport is the queue itself; the slave side is memory and fetch stage together.
interface riscv_ifq_if;
    import riscv_ifq_pkg::*;

    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;

    logic            o_ifq_valid;
    logic [XLEN-1:0] o_ifq_pc;
    logic [XLEN-1:0] o_ifq_instr;
    logic            i_ifq_ready;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_rvalid, i_imem_rdata,
        output o_ifq_valid, o_ifq_pc, o_ifq_instr,
        input  i_ifq_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_rvalid, i_imem_rdata,
        input  o_ifq_valid, o_ifq_pc, o_ifq_instr,
        output i_ifq_ready
    );

endinterface

// File: rtl/riscv_ifq_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instr} entries; flush empties it in one cycle.
module riscv_ifq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
            if (i_push) wptr <= wptr + AW'(1);
            if (i_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    // NOTE: the storage array is not reset; count/empty gate every read, so its contents never leak.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) mem[wptr] <= i_wdata;
    end

    assign o_rdata = mem[rptr];
    assign o_full  = (count == FULL_CNT);
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule

// File: rtl/riscv_ifq.sv
// Instruction fetch queue between the CPU fetch stage and a registered instruction memory.
// Requests are throttled so queued plus in-flight words never exceed DEPTH; redirects drain stale responses.
module riscv_ifq
    import riscv_ifq_pkg::*;
#(
    parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int               DEPTH    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_redirect,
    input  logic [`XLEN-1:0]  i_redirect_pc,
    riscv_ifq_if.master       bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    ifq_state_e      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    ifq_entry_t      wr_entry;
    ifq_entry_t      rd_entry;

    logic            imem_req;
    logic            resp;
    logic            push;
    logic            pop;
    logic            ifq_valid;
    logic [CW:0]     inflight;
    logic [CW-1:0]   out_after_resp;

    assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req       = (state == FETCH) && (inflight < {1'b0, DEPTH_CNT}) && !i_redirect && !i_rst;
    assign resp           = bus.i_imem_rvalid && !i_rst;
    assign push           = resp && (state == FETCH) && !i_redirect;
    assign ifq_valid      = !fifo_empty && !i_redirect && !i_rst;
    assign pop            = ifq_valid && bus.i_ifq_ready;
    assign out_after_resp = outstanding - CW'(resp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(imem_req) - CW'(resp);
            if (i_redirect) begin
                // Whatever is still in flight after this cycle belongs to the old stream.
                fetch_pc <= align_pc(i_redirect_pc);
                resp_pc  <= align_pc(i_redirect_pc);
                discard  <= out_after_resp;
                state    <= (out_after_resp != '0) ? DRAIN : FETCH;
            end else begin
                if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)     resp_pc  <= resp_pc + XLEN'(4);
                if (state == DRAIN && resp) begin
                    discard <= discard - CW'(1);
                    if (discard == CW'(1)) state <= FETCH;
                end
            end
        end
    end

    // The throttle on imem_req must make this unreachable.
    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!(push && fifo_full));
    end

    assign wr_entry = '{pc: resp_pc, instr: bus.i_imem_rdata};

    riscv_ifq_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_push  (push),
        .i_wdata (wr_entry),
        .i_pop   (pop),
        .o_rdata (rd_entry),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign bus.o_imem_req  = imem_req;
    assign bus.o_imem_addr = fetch_pc;
    assign bus.o_ifq_valid = ifq_valid;
    assign bus.o_ifq_pc    = rd_entry.pc;
    assign bus.o_ifq_instr = rd_entry.instr;

endmodule

// File: doc/riscv_ifq.md
RISCV_IFQ -- requirements
Module: riscv_ifq

Interface
REQ-001 Parameters SHALL be:
  - RESET_PC, default 32'h0000_0000, first fetch address after reset.
  - DEPTH, default 4, queue entries and maximum outstanding requests; power of two, at least 2.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset; one clock; synchronous, active-high.
REQ-004 i_redirect  input  1  flush queue and restart fetch (branch, jump or trap from the CPU).
REQ-005 i_redirect_pc  input  `XLEN  new fetch address; bits [1:0] ignored, treated as 0.
REQ-006 o_imem_req  output  1  fetch request to synchronous instruction memory; always accepted in the cycle it is asserted.
REQ-007 o_imem_addr  output  `XLEN  byte address of the request.
REQ-008 i_imem_rvalid  input  1  response valid; responses return in order, at most one per cycle, one or more cycles after the request.
REQ-009 i_imem_rdata  input  `XLEN  instruction word returned with the response.
REQ-010 o_ifq_valid  output  1  the head entry is available to the CPU.
REQ-011 o_ifq_pc  output  `XLEN  PC of the head entry.
REQ-012 o_ifq_instr  output  `XLEN  instruction of the head entry.
REQ-013 i_ifq_ready  input  1  CPU accepts the head entry; a pop occurs when o_ifq_valid and i_ifq_ready are both 1.

Function
REQ-014 The queue SHALL be show-ahead: head fields SHALL be valid in the same cycle as o_ifq_valid, and o_ifq_valid SHALL equal (count != 0) and not i_redirect.
REQ-015 The FSM SHALL have two states, FETCH and DRAIN.
REQ-016 o_imem_req SHALL be 1 only when all hold: state is FETCH; count + outstanding < DEPTH; i_redirect is 0; i_rst is 0.
REQ-017 On each issued request:
  - o_imem_addr SHALL equal fetch_pc.
  - fetch_pc SHALL advance by 4, wrapping modulo 2^XLEN.
  - outstanding SHALL increment.
REQ-018 On each response in FETCH:
  - {resp_pc, i_imem_rdata} SHALL be pushed.
  - resp_pc SHALL advance by 4.
  - outstanding SHALL decrement.
  - The entry SHALL become visible on o_ifq_valid in the next cycle.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-020 REQ-016 SHALL guarantee the queue never overflows; a push to a full queue is a design error and SHALL be flagged by an assertion.
REQ-021 On i_redirect at cycle T:
  - count SHALL become 0.
  - fetch_pc and resp_pc SHALL both become {i_redirect_pc[XLEN-1:2], 2'b00}.
  - A pop requested in cycle T SHALL be ignored.
  - A response arriving in cycle T SHALL be discarded.
REQ-022 After a redirect at T, let N be outstanding minus any response arriving at T:
  - If N > 0, the FSM SHALL enter DRAIN with discard = N.
  - Otherwise it SHALL enter FETCH, with the first request at T+1.
REQ-023 In DRAIN:
  - Each response SHALL decrement discard and outstanding and SHALL NOT be pushed.
  - When discard reaches 0, the FSM SHALL enter FETCH in the next cycle.
  - No request SHALL issue while in DRAIN.
REQ-024 A redirect during DRAIN SHALL restart the drain with discard set to the remaining outstanding count, and SHALL load the new PC.
REQ-025 With a 1-cycle memory, redirect at T SHALL give: request at T+1, response at T+2, o_ifq_valid=1 at T+3.

Reset
REQ-026 While i_rst=1:
  - state SHALL be FETCH.
  - fetch_pc and resp_pc SHALL be RESET_PC.
  - count, outstanding and discard SHALL be 0.
  - Pointers SHALL be 0.
  - o_imem_req and o_ifq_valid SHALL be 0.
  - Responses SHALL be ignored.
REQ-027 Reset mid-operation SHALL abandon all in-flight requests; the memory model SHALL be reset in the same cycle.
REQ-028 The first request after reset SHALL issue in the first cycle with i_rst=0, at address RESET_PC.

Structure
REQ-029 `XLEN and `IMEM_ADDR_BIT SHALL come from the shared RISC-V defines header; the FETCH/DRAIN encodings SHALL be local parameters.
REQ-030 Storage SHALL be a sub-module riscv_ifq_fifo: a synchronous FIFO of width 2*XLEN and depth DEPTH, with flush, push, pop, full, empty and count.
REQ-031 The riscv_ifq SHALL sit between the pipelined CPU fetch stage and a registered riscv_imem.

Verification
REQ-032 Reset release, 1-cycle memory, i_ifq_ready=1 -> requests at addresses 0, 4, 8, ...; entries {pc 0, instr mem[0]} and onward pop one per cycle with no gaps once streaming.
REQ-033 i_ifq_ready=0 for 20 cycles -> exactly 4 entries queued, o_imem_req=0, outstanding=0; ready=1 then pops PCs 0, 4, 8, 12 in order.
REQ-034 3-cycle memory latency, 3 requests outstanding, redirect to 32'h0000_0103 -> DRAIN discards 3 responses; first pushed entry is pc 32'h100; no stale PC ever appears on o_ifq_pc.
REQ-035 Redirect coinciding with a response, and a pop in the same cycle -> response dropped, pop ignored, o_ifq_valid=0 at T and T+1, count=0.
REQ-036 fetch_pc = 32'hFFFF_FFFC -> the next request wraps to address 0; i_rst asserted mid-DRAIN -> fetch restarts at RESET_PC with no stale entry pushed.
